// File: rtl/fetch_prefetch_buffer_if.sv
// rtl/fetch_prefetch_buffer_if.sv - fetch front-end bus: redirect, core-side head, instruction memory port
interface fetch_prefetch_buffer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        consume;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport master (
        input  redirect_valid, redirect_pc, consume,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output out_valid, out_pc, out_instr,
        output mem_req_valid, mem_req_addr
    );

    modport slave (
        output redirect_valid, redirect_pc, consume,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  out_valid, out_pc, out_instr,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - sequential instruction prefetcher with {pc, instr} FIFO and redirect flush
module fetch_prefetch_buffer #(
    parameter int          DEPTH            = 4,
    parameter logic [31:0] PC_START_ADDRESS = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_prefetch_buffer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_SLOTS = (CW+1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    cnt_t        count_q, count_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        drop_count_q, drop_count_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];

    logic        req_fire;
    logic        rsp_live;
    logic        push;
    logic        pop;
    logic [CW:0] slots_used;
    cnt_t        count_after_pop;
    logic [31:0] redirect_target;
    logic        redirect_pc_lsb_unused;

    assign redirect_target        = {bus.redirect_pc[31:2], 2'b00};
    assign redirect_pc_lsb_unused = ^bus.redirect_pc[1:0];

    // Buffered entries plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign slots_used        = {1'b0, count_q} + {1'b0, outstanding_q};
    assign bus.mem_req_valid = ~rst & ~bus.redirect_valid & (slots_used < DEPTH_SLOTS);
    assign bus.mem_req_addr  = fetch_pc_q;

    assign req_fire = bus.mem_req_valid & bus.mem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored outright.
    assign rsp_live = bus.mem_rsp_valid & (outstanding_q != '0);
    assign push     = rsp_live & (drop_count_q == '0) & ~bus.redirect_valid;
    assign pop      = bus.consume & (count_q != '0) & ~bus.redirect_valid;

    assign count_after_pop = count_q - cnt_t'(pop);

    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_live);
        drop_count_d  = drop_count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        out_pc_d      = 32'h0;
        out_instr_d   = 32'h0;

        if (bus.redirect_valid) begin
            // Every response still in flight after this cycle belongs to the abandoned path.
            fetch_pc_d   = redirect_target;
            rsp_pc_d     = redirect_target;
            drop_count_d = outstanding_q - cnt_t'(rsp_live);
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_live && (drop_count_q != '0)) begin
                drop_count_d = drop_count_q - cnt_t'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);

            // The head register is loaded with whatever entry sits at the head after this cycle.
            if (count_d == '0) begin
                out_pc_d    = 32'h0;
                out_instr_d = 32'h0;
            end else if (count_after_pop == '0) begin
                out_pc_d    = rsp_pc_q;
                out_instr_d = bus.mem_rsp_data;
            end else begin
                out_pc_d    = fifo_pc_q[rd_ptr_d];
                out_instr_d = fifo_instr_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= PC_START_ADDRESS;
            rsp_pc_q      <= PC_START_ADDRESS;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            out_pc_q      <= 32'h0;
            out_instr_q   <= 32'h0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - scoreboard bench for fetch_prefetch_buffer with in-order latency memory model
module tb_fetch_prefetch_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_buffer_if bus_if ();

    fetch_prefetch_buffer #(
        .DEPTH           (DEPTH),
        .PC_START_ADDRESS(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] watch_reqs[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          t;
    int          lat_min, lat_max;
    int          acc_count, pop_count, first_valid_t;
    int          watch_req_t, watch_out_t;
    logic [31:0] watch_out_pc;
    bit          watch, got_out, random_mode;
    logic [31:0] model_pc;
    logic [31:0] last_acc_addr;

    logic        drv_consume, drv_ready, drv_redirect;
    logic [31:0] drv_redirect_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0d)", tag, act, exp, t);
        end
    endtask

    task automatic clear_watch();
        watch        = 1'b0;
        got_out      = 1'b0;
        watch_req_t  = -1;
        watch_out_t  = -1;
        watch_out_pc = 32'h0;
        watch_reqs.delete();
    endtask

    // Called at a falling edge: drive inputs, settle, score, then advance to the next falling edge.
    task automatic do_cycle();
        mem_req_t m;
        exp_t     e;
        if (random_mode) begin
            drv_ready       = 1'($urandom_range(0, 1));
            drv_consume     = 1'($urandom_range(0, 1));
            drv_redirect    = ((t % 50) == 37);
            drv_redirect_pc = $urandom();
        end
        if (mem_q.size() > 0 && mem_q[0].due <= t) begin
            bus_if.mem_rsp_valid = 1'b1;
            bus_if.mem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus_if.mem_rsp_valid = 1'b0;
            bus_if.mem_rsp_data  = 32'h0;
        end
        bus_if.consume        = drv_consume;
        bus_if.mem_req_ready  = drv_ready;
        bus_if.redirect_valid = drv_redirect;
        bus_if.redirect_pc    = drv_redirect_pc;
        #1;

        if (bus_if.out_valid) begin
            if (first_valid_t < 0) first_valid_t = t;
            if (watch && !got_out) begin
                got_out      = 1'b1;
                watch_out_pc = bus_if.out_pc;
                watch_out_t  = t;
            end
            if (exp_q.size() == 0) begin
                check_eq("head_without_expected_entry", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("out_pc", bus_if.out_pc, exp_q[0].pc);
                check_eq("out_instr", bus_if.out_instr, exp_q[0].instr);
                if (drv_consume && !drv_redirect) begin
                    void'(exp_q.pop_front());
                    pop_count++;
                end
            end
        end else begin
            check_eq("empty_out_pc", bus_if.out_pc, 32'h0);
            check_eq("empty_out_instr", bus_if.out_instr, 32'h0);
        end

        if (drv_redirect) begin
            check_eq("req_during_redirect", 32'(bus_if.mem_req_valid), 32'd0);
            exp_q.delete();
            model_pc = {drv_redirect_pc[31:2], 2'b00};
        end

        if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
            check_eq("req_addr", bus_if.mem_req_addr, model_pc);
            acc_count++;
            last_acc_addr = bus_if.mem_req_addr;
            if (watch) begin
                if (watch_req_t < 0) watch_req_t = t;
                watch_reqs.push_back(bus_if.mem_req_addr);
            end
            m.addr = bus_if.mem_req_addr;
            m.due  = t + $urandom_range(lat_max, lat_min);
            mem_q.push_back(m);
            e.pc    = model_pc;
            e.instr = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end

        check_eq("live_entries_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
        @(negedge clk);
        t++;
    endtask

    // Asserts rst between clock edges, checks the asynchronous reset state, releases on a falling edge.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.consume        = 1'b0;
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_rsp_valid  = 1'b0;
        bus_if.mem_rsp_data   = 32'h0;
        #1;
        check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("rst_mem_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
        check_eq("rst_out_pc", bus_if.out_pc, 32'h0);
        check_eq("rst_out_instr", bus_if.out_instr, 32'h0);
        check_eq("rst_mem_req_addr", bus_if.mem_req_addr, 32'h0);
        mem_q.delete();
        exp_q.delete();
        model_pc      = 32'h0;
        drv_consume   = 1'b0;
        drv_ready     = 1'b0;
        drv_redirect  = 1'b0;
        random_mode   = 1'b0;
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        t             = 0;
        first_valid_t = -1;
        acc_count     = 0;
        pop_count     = 0;
        clear_watch();
    endtask

    initial begin
        drv_redirect_pc = 32'h0;
        lat_min = 1;
        lat_max = 1;
        apply_reset();

        // Streaming with a 1-cycle memory and a consuming core.
        drv_ready = 1'b1; drv_consume = 1'b1;
        repeat (12) do_cycle();
        check_eq("t1_first_valid_cycle", 32'(first_valid_t), 32'd2);
        check_eq("t1_pops", 32'(pop_count), 32'd10);
        check_eq("t1_requests", 32'(acc_count), 32'd12);

        // Core stalled: issue stops once DEPTH slots are reserved; one consume frees one slot.
        apply_reset();
        drv_ready = 1'b1; drv_consume = 1'b0;
        repeat (10) do_cycle();
        check_eq("t2_requests_full", 32'(acc_count), 32'd4);
        check_eq("t2_req_valid_full", 32'(bus_if.mem_req_valid), 32'd0);
        check_eq("t2_buffered", 32'(exp_q.size()), 32'd4);
        drv_consume = 1'b1;
        do_cycle();
        drv_consume = 1'b0;
        repeat (5) do_cycle();
        check_eq("t2_requests_after_pop", 32'(acc_count), 32'd5);
        check_eq("t2_refill_addr", last_acc_addr, 32'h10);

        // Redirect with three requests in flight on a 3-cycle memory.
        apply_reset();
        lat_min = 3; lat_max = 3;
        drv_ready = 1'b1; drv_consume = 1'b1;
        repeat (3) do_cycle();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h100;
        do_cycle();
        drv_redirect = 1'b0;
        watch = 1'b1;
        repeat (15) do_cycle();
        check_eq("t3_first_req_cycle", 32'(watch_req_t), 32'd4);
        check_eq("t3_first_req_count", 32'(watch_reqs.size() > 0), 32'd1);
        if (watch_reqs.size() > 0) check_eq("t3_first_req_addr", watch_reqs[0], 32'h100);
        check_eq("t3_first_out_pc", watch_out_pc, 32'h100);
        check_eq("t3_first_out_cycle", 32'(watch_out_t), 32'd8);

        // Redirect coinciding with a response and a consume, two requests outstanding.
        apply_reset();
        lat_min = 2; lat_max = 2;
        drv_ready = 1'b1; drv_consume = 1'b0;
        repeat (3) do_cycle();
        check_eq("t4_head_before_redirect", 32'(bus_if.out_valid), 32'd1);
        drv_redirect = 1'b1; drv_redirect_pc = 32'h200; drv_consume = 1'b1;
        do_cycle();
        drv_redirect = 1'b0;
        check_eq("t4_flushed", 32'(bus_if.out_valid), 32'd0);
        watch = 1'b1;
        repeat (10) do_cycle();
        check_eq("t4_first_out_pc", watch_out_pc, 32'h200);
        check_eq("t4_first_out_cycle", 32'(watch_out_t), 32'd7);

        // Random ready/consume/latency with periodic redirects.
        apply_reset();
        lat_min = 1; lat_max = 3;
        random_mode = 1'b1;
        repeat (1000) do_cycle();
        random_mode = 1'b0;
        drv_redirect = 1'b0;
        check_eq("t5_progress", 32'(pop_count > 100), 32'd1);

        // Unaligned target at the top of the address space, then a mid-stream reset.
        apply_reset();
        lat_min = 1; lat_max = 1;
        drv_ready = 1'b1; drv_consume = 1'b1;
        repeat (3) do_cycle();
        drv_redirect = 1'b1; drv_redirect_pc = 32'hFFFF_FFFE;
        do_cycle();
        drv_redirect = 1'b0;
        watch = 1'b1;
        repeat (6) do_cycle();
        check_eq("t6_wrap_req_count", 32'(watch_reqs.size() >= 2), 32'd1);
        if (watch_reqs.size() >= 2) begin
            check_eq("t6_aligned_addr", watch_reqs[0], 32'hFFFF_FFFC);
            check_eq("t6_wrapped_addr", watch_reqs[1], 32'h0000_0000);
        end
        check_eq("t6_first_out_pc", watch_out_pc, 32'hFFFF_FFFC);
        apply_reset();
        drv_ready = 1'b1; drv_consume = 1'b1;
        watch = 1'b1;
        repeat (6) do_cycle();
        check_eq("t6_restart_req_count", 32'(watch_reqs.size() > 0), 32'd1);
        if (watch_reqs.size() > 0) check_eq("t6_restart_addr", watch_reqs[0], 32'h0);
        check_eq("t6_restart_first_valid", 32'(first_valid_t), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
